// File: rtl/glyph_stream.sv
// Glyph memory with a row-serialising read port: a request selects one glyph,
// which is latched whole and then streamed one GLYPH_W-bit row per beat.
module glyph_stream #(
  parameter int    GLYPH_W   = 10,
  parameter int    GLYPH_H   = 10,
  parameter int    DEPTH     = 16,
  parameter int    IDX_W     = 4,
  parameter string INIT_FILE = "",
  localparam int   RN_W      = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1,
  localparam int   BMP_W     = GLYPH_W * GLYPH_H
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [IDX_W-1:0]   req_idx,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [BMP_W-1:0]   wr_data,
  output logic               row_valid,
  input  logic               row_ready,
  output logic [GLYPH_W-1:0] row_data,
  output logic [RN_W-1:0]    row_num,
  output logic               row_last,
  output logic               oob
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready, and ready is decoded from state.

  typedef enum logic [1:0] {IDLE, FETCH, STREAM} state_t;

  localparam logic [IDX_W:0]  DEPTH_C  = (IDX_W + 1)'(DEPTH);
  localparam logic [RN_W-1:0] LAST_ROW = RN_W'(GLYPH_H - 1);

  state_t             state;
  state_t             state_nxt;
  logic [BMP_W-1:0]   mem [DEPTH];
  logic [IDX_W-1:0]   idx_q;
  logic [RN_W-1:0]    row_cnt;
  logic [GLYPH_W-1:0] glyph_rows [GLYPH_H];
  logic [BMP_W-1:0]   fetch_word;
  logic               idx_ok;
  logic               wr_ok;
  logic               accept;
  logic               last_row;

  assign idx_ok   = ({1'b0, idx_q} < DEPTH_C);
  assign wr_ok    = ({1'b0, wr_idx} < DEPTH_C);
  assign accept   = req_valid && (state == IDLE);
  assign last_row = (row_cnt == LAST_ROW);

  // Power-up image for the glyph store; the store itself is never reset.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  end

  always_ff @(posedge clk) begin
    if (wr_en && wr_ok) mem[wr_idx] <= wr_data;
  end

  // Bad indices read as blank so the stream still completes normally.
  assign fetch_word = idx_ok ? mem[idx_q] : '0;

  // Read and write share the edge, so a same-slot write in FETCH is not seen.
  always_ff @(posedge clk) begin
    if (state == FETCH) begin
      for (int r = 0; r < GLYPH_H; r++)
        glyph_rows[r] <= fetch_word[(GLYPH_H - r) * GLYPH_W - 1 -: GLYPH_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = FETCH;
      FETCH:   state_nxt = STREAM;
      STREAM:  if (row_ready && last_row) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= '0;
      row_cnt <= '0;
      oob     <= 1'b0;
    end else begin
      if (accept) idx_q <= req_idx;
      if (state == FETCH) begin
        row_cnt <= '0;
        if (!idx_ok) oob <= 1'b1;
      end else if (state == STREAM && row_ready) begin
        row_cnt <= last_row ? '0 : row_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    req_ready = (state == IDLE);
    row_valid = (state == STREAM);
    row_num   = row_cnt;
    row_last  = (state == STREAM) && last_row;
    row_data  = (state == STREAM) ? glyph_rows[row_cnt] : '0;
  end

endmodule
